// File: rtl/nubus_master.sv
// NuBus bus-initiator: turns single-word read/write requests into NuBus transactions.
// Optional build macro NUBUS_MASTER_RETRY_EN enables automatic reissue on RETRY status.
module nubus_master #(
   parameter int unsigned TIMEOUT   = 255,
   parameter int unsigned MAX_RETRY = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic [1:0]  rsp_status,
   output logic        rqst_o,
   input  logic        grant_i,
   output logic        start_o,
   input  logic        ack_i,
   output logic [1:0]  tm_o,
   input  logic [1:0]  tm_i,
   output logic [31:0] ad_o,
   input  logic [31:0] ad_i,
   output logic        ad_oe,
   output logic        ctl_oe
);

   typedef enum logic [2:0] {
      S_IDLE, S_ARB, S_START, S_DATA, S_WAIT, S_DONE
   } state_t;

   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   state_t      state;
   logic        write;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [7:0]  cnt;
   logic [7:0]  cnt_next;
   logic        timed_out;

`ifdef NUBUS_MASTER_RETRY_EN
   localparam logic [7:0] MAX_RETRY_CNT = 8'(MAX_RETRY);
   logic [7:0] retry_cnt;
   logic       retry_now;
`endif

   // Counter value equals clocks elapsed since START, saturating at all-ones.
   always_comb begin
      cnt_next  = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
      timed_out = (cnt == TIMEOUT_CNT);
`ifdef NUBUS_MASTER_RETRY_EN
      retry_now = (tm_i == 2'b11) && (retry_cnt < MAX_RETRY_CNT);
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         write      <= 1'b0;
         addr       <= '0;
         wdata      <= '0;
         cnt        <= '0;
         req_ready  <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= '0;
         rsp_status <= 2'b00;
         rqst_o     <= 1'b0;
         start_o    <= 1'b0;
         tm_o       <= 2'b00;
         ad_o       <= '0;
         ad_oe      <= 1'b0;
         ctl_oe     <= 1'b0;
`ifdef NUBUS_MASTER_RETRY_EN
         retry_cnt  <= '0;
`endif
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  write     <= req_write;
                  addr      <= req_addr & 32'hFFFF_FFFC;
                  wdata     <= req_wdata;
                  req_ready <= 1'b0;
                  rqst_o    <= 1'b1;
                  state     <= S_ARB;
`ifdef NUBUS_MASTER_RETRY_EN
                  retry_cnt <= '0;
`endif
               end
            end
            S_ARB: begin
               if (grant_i) begin
                  rqst_o  <= 1'b0;
                  start_o <= 1'b1;
                  ctl_oe  <= 1'b1;
                  ad_oe   <= 1'b1;
                  ad_o    <= addr;
                  tm_o    <= {1'b0, write};
                  cnt     <= '0;
                  state   <= S_START;
               end
            end
            S_START: begin
               start_o <= 1'b0;
               cnt     <= cnt_next;
               if (write) begin
                  ad_o <= wdata;
               end else begin
                  ad_o  <= '0;
                  ad_oe <= 1'b0;
               end
               state <= S_DATA;
            end
            S_DATA, S_WAIT: begin
               cnt <= cnt_next;
               // ACK is tested before the timeout so a same-cycle ACK wins.
`ifdef NUBUS_MASTER_RETRY_EN
               if (ack_i && retry_now) begin
                  retry_cnt <= retry_cnt + 8'd1;
                  rqst_o    <= 1'b1;
                  ad_oe     <= 1'b0;
                  ctl_oe    <= 1'b0;
                  ad_o      <= '0;
                  tm_o      <= 2'b00;
                  state     <= S_ARB;
               end else
`endif
               if (ack_i) begin
                  rsp_valid  <= 1'b1;
                  rsp_status <= tm_i;
                  rsp_rdata  <= write ? '0 : ad_i;
                  ad_oe      <= 1'b0;
                  ctl_oe     <= 1'b0;
                  ad_o       <= '0;
                  tm_o       <= 2'b00;
                  state      <= S_DONE;
               end else if (timed_out) begin
                  rsp_valid  <= 1'b1;
                  rsp_status <= 2'b10;
                  if (write) rsp_rdata <= '0;
                  ad_oe      <= 1'b0;
                  ctl_oe     <= 1'b0;
                  ad_o       <= '0;
                  tm_o       <= 2'b00;
                  state      <= S_DONE;
               end else begin
                  state <= S_WAIT;
               end
            end
            S_DONE: begin
               req_ready <= 1'b1;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
